sram_mem_responder: RTL and testbench
=====================================

// Module: sram_mem_responder
// PURPOSE
//  Memory-stage responder for the load/store requests (mem_read / mem_write)
//  raised by the instruction decoder and carried down the pipeline.
//  Translates the byte address into a word address and runs a fixed-latency
//  access on an external asynchronous SRAM.
//  Holds ready low until the access completes; the pipeline uses ~ready as its
//  freeze signal. Returns load data to write-back.
// PARAMETERS
//  DATA_W       32    data width of pipeline and SRAM word
//  SRAM_ADDR_W  16    SRAM word-address width
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
//  WAIT_CYCLES  5     cycles spent in ACCESS per request (>=1)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous active-low reset
//  mem_read     in   1            load request from the EXE/MEM register
//  mem_write    in   1            store request from the EXE/MEM register
//  addr         in   32           byte address (ALU result)
//  st_val       in   DATA_W       store data
//  ready        out  1            1 = no pending access; 0 = freeze pipeline
//  rd_data      out  DATA_W       load result, valid while state==DONE
//  err          out  1            access fault pulse (MEM_RANGE_CHECK_EN only)
//  sram_addr    out  SRAM_ADDR_W  SRAM word address
//  sram_dq_out  out  DATA_W       SRAM write data
//  sram_dq_oe   out  1            1 = drive sram_dq_out onto the bus
//  sram_dq_in   in   DATA_W       SRAM read data
//  sram_we_n    out  1            SRAM write enable, active low
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; cnt=0; rd_data=0; sram_addr=0; sram_dq_out=0; sram_dq_oe=0;
//     sram_we_n=1; err=0.
//   - Reset asserted mid-access aborts it immediately: WE released and bus
//     tristated; no partial completion is signalled.
//  FSM states: IDLE, ACCESS, DONE.
//   - IDLE:   req = mem_read|mem_write. On req, latch op/addr/st_val, cnt<=0,
//             go to ACCESS. With no req, stay in IDLE.
//   - ACCESS: stay while cnt<WAIT_CYCLES-1 (cnt++). At cnt==WAIT_CYCLES-1,
//             go to DONE; for a read, rd_data<=sram_dq_in on that edge.
//   - DONE:   one cycle only, then IDLE unconditionally, even if req is still
//             high. The pipeline advances on this edge, so the next IDLE sees
//             the next instruction.
//  ready (combinational):
//   - ready = (state==IDLE & ~req) | (state==DONE).
//   - Request seen at cycle k: ready=0 for cycles k..k+WAIT_CYCLES, ready=1
//     at k+WAIT_CYCLES+1.
//  Address translation:
//   - sram_addr = ((addr - BASE_ADDR) >> 2)[SRAM_ADDR_W-1:0], registered at
//     the latch edge and held through DONE.
//   - Subtraction is 32-bit modulo; addr[1:0] is ignored.
//  Store:
//   - sram_we_n=0 and sram_dq_oe=1 for every ACCESS cycle.
//   - Both are deasserted in DONE and IDLE; sram_dq_out holds latched st_val.
//  Load:
//   - sram_we_n=1 and sram_dq_oe=0 throughout.
//   - rd_data holds its value until the next read completes.
//  Simultaneous mem_read & mem_write (never decoded): treated as a store.
//  Inputs are not re-sampled in ACCESS/DONE; the frozen pipeline holds them.
// CONFIGURATION
//  Macro MEM_RANGE_CHECK_EN.
//   - Defined: in IDLE, a req with addr<BASE_ADDR,
//     addr>=BASE_ADDR+4*2**SRAM_ADDR_W, or addr[1:0]!=0 goes directly to
//     DONE. No SRAM activity (we_n=1, oe=0). rd_data<=0 for a read. err=1
//     during that DONE cycle only.
//   - Undefined: no check; out-of-range addresses wrap modulo SRAM size;
//     err is tied to 0.
// TESTING
//  1. Reset: rst_n=0 with mem_write=1 -> ready=1 once rst_n rises and
//     mem_write=0; sram_we_n=1, sram_dq_oe=0, rd_data=0.
//  2. Store: mem_write=1, addr=1028, st_val=32'hDEADBEEF at cycle 0
//     -> sram_addr=1; we_n=0 and oe=1 in cycles 1-5; ready=0 in cycles 0-5;
//     ready=1 at cycle 6.
//  3. Load: model returns 32'h12345678 at word 1; mem_read=1, addr=1028
//     -> rd_data=32'h12345678 at cycle 6; we_n stays 1 throughout.
//  4. Back-to-back: load held high through DONE, then a store presented the
//     next cycle -> exactly one read and one write access; no duplicate
//     access from the held request.
//  5. Abort: rst_n pulsed low in cycle 3 of a store -> we_n=1 and oe=0
//     immediately; state=IDLE; no DONE cycle.
//  6. MEM_RANGE_CHECK_EN: mem_read, addr=1000 -> ready=1 and err=1 at
//     cycle 1, rd_data=0, no SRAM strobes.
//     Without the macro: sram_addr=16'hFFFA (wrap); normal 6-cycle access.

Source files
------------

// File: rtl/sram_mem_responder.sv
// Memory-stage load/store responder driving a fixed-latency asynchronous SRAM.
// Optional address fault detection is enabled by defining MEM_RANGE_CHECK_EN.
module sram_mem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      st_val,
  output logic                   ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [DATA_W-1:0]      sram_dq_in,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]      dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   we_n_q, we_n_d;
  logic                   req;
  logic                   fault;
  logic [31:0]            diff;
  logic                   unused_diff;

  assign req  = mem_read | mem_write;
  assign diff = addr - BASE_ADDR;
  assign unused_diff = ^{diff[31:SRAM_ADDR_W+2], diff[1:0]};

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(BASE_ADDR) + (33'd4 << SRAM_ADDR_W);
  logic err_q, err_d;

  // Compare in 33 bits so the upper bound cannot wrap.
  assign fault = ({1'b0, addr} < 33'(BASE_ADDR)) || ({1'b0, addr} >= ADDR_LIMIT) ||
                 (addr[1:0] != 2'b00);
  assign err   = err_q;
`else
  assign fault = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    rd_data_d   = rd_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
`ifdef MEM_RANGE_CHECK_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          is_wr_d = mem_write;
          if (fault) begin
            state_d = DONE;
            if (!mem_write) rd_data_d = '0;
`ifdef MEM_RANGE_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            sram_addr_d = diff[SRAM_ADDR_W+1:2];
            dq_out_d    = st_val;
            we_n_d      = ~mem_write;
            dq_oe_d     = mem_write;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          if (!is_wr_q) rd_data_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
`ifdef MEM_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign rd_data     = rd_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed plus randomized bench for sram_mem_responder with an SRAM model
// and a word-array reference model; MEM_RANGE_CHECK_EN selects fault checks.
module tb_sram_mem_responder;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 16;
  localparam int unsigned BASE = 1024;
  localparam int unsigned W    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]   addr = '0;
  logic [DW-1:0] st_val = '0;
  logic          ready, err, sram_dq_oe, sram_we_n;
  logic [DW-1:0] rd_data, sram_dq_out, sram_dq_in;
  logic [AW-1:0] sram_addr;

  sram_mem_responder #(.DATA_W(DW), .SRAM_ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .st_val(st_val), .ready(ready), .rd_data(rd_data), .err(err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: 256 words, asynchronous read, write while WE low and bus driven.
  logic [DW-1:0] sram_arr [256];
  logic          pre_en = 1'b0;
  logic [7:0]    pre_idx = '0;
  logic [DW-1:0] pre_dat = '0;
  int unsigned   we_low_cycles = 0;

  assign sram_dq_in = sram_arr[sram_addr[7:0]];

  always @(posedge clk) begin
    if (pre_en) sram_arr[pre_idx] = pre_dat;
    else if (!sram_we_n) begin
      we_low_cycles = we_low_cycles + 1;
      if (sram_dq_oe) sram_arr[sram_addr[7:0]] = sram_dq_out;
    end
  end

  // Reference model: word contents as seen by the program, plus last load value.
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_rd = '0;
  int unsigned   tests = 0;
  int unsigned   fails = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off >> 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned i, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_idx = 8'(i); pre_dat = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
    model[i] = d;
  endtask

  // Entered 1 time unit after a rising edge (cycle 0); returns in the cycle after DONE.
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [DW-1:0] d,
                           input bit hold);
    int unsigned wl0;
    logic [31:0] w;
    w   = word_of(a);
    wl0 = we_low_cycles;
    mem_write = wr; mem_read = !wr; addr = a; st_val = d;
    @(negedge clk);
    chk("req_ready", ready, 0);
    for (int c = 1; c <= int'(W); c++) begin
      @(posedge clk); #1; @(negedge clk);
      chk("acc_ready", ready, 0);
      chk("acc_we_n", sram_we_n, !wr);
      chk("acc_oe", sram_dq_oe, wr);
      chk("acc_addr", sram_addr, w & 32'hFFFF);
      if (wr) chk("acc_dq", sram_dq_out, d);
    end
    @(posedge clk); #1; @(negedge clk);
    chk("done_ready", ready, 1);
    chk("done_we_n", sram_we_n, 1);
    chk("done_oe", sram_dq_oe, 0);
    chk("done_err", err, 0);
    if (wr) begin
      model[w & 255] = d;
      chk("rd_hold", rd_data, last_rd);
    end else begin
      last_rd = model[w & 255];
      chk("rd_data", rd_data, last_rd);
    end
    chk("we_cycles", we_low_cycles - wl0, wr ? W : 0);
    @(posedge clk); #1;
    if (!hold) begin mem_read = 1'b0; mem_write = 1'b0; end
  endtask

  initial begin
    logic [31:0] a, d;
    bit wr;
    int unsigned i;

    // Reset with a store request pending; fill SRAM and model meanwhile.
    rst_n = 1'b0; mem_write = 1'b1; addr = 32'd1028;
    for (int k = 0; k < 256; k++) preload(k, $urandom);
    @(negedge clk);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_ready_req", ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    @(posedge clk); #1;

    // Directed store then load at byte 1028 (word 1).
    do_access(1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
    chk("st_addr", sram_addr, 1);
    preload(1, 32'h12345678);
    do_access(1'b0, 32'd1028, '0, 1'b0);
    chk("ld_val", rd_data, 32'h12345678);

    // Load held high through DONE, store presented on the following cycle.
    do_access(1'b0, BASE + 4 * 9, '0, 1'b1);
    do_access(1'b1, BASE + 4 * 10, 32'hCAFE0001, 1'b0);
    do_access(1'b0, BASE + 4 * 10, '0, 1'b0);
    chk("b2b_rd", rd_data, 32'hCAFE0001);

    // Reset pulsed during cycle 3 of a store.
    mem_write = 1'b1; addr = BASE + 4 * 7; st_val = 32'hA5A5_5A5A;
    for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort_pre_we", sram_we_n, 0);
    rst_n = 1'b0; #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_oe", sram_dq_oe, 0);
    mem_write = 1'b0; #1;
    chk("abort_ready", ready, 1);
    model[7] = 32'hA5A5_5A5A;
    last_rd = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < int'(W) + 2; c++) begin
      @(negedge clk);
      chk("abort_idle_ready", ready, 1);
      chk("abort_idle_we", sram_we_n, 1);
      chk("abort_idle_rd", rd_data, 0);
      @(posedge clk); #1;
    end

`ifdef MEM_RANGE_CHECK_EN
    // Faulting accesses complete in one cycle with err and no SRAM strobes.
    for (int t = 0; t < 2; t++) begin
      mem_read = 1'b1; addr = (t == 0) ? 32'd1000 : 32'd1030;
      @(negedge clk);
      chk("flt_req_ready", ready, 0);
      @(posedge clk); #1; @(negedge clk);
      chk("flt_ready", ready, 1);
      chk("flt_err", err, 1);
      chk("flt_rd", rd_data, 0);
      chk("flt_we_n", sram_we_n, 1);
      chk("flt_oe", sram_dq_oe, 0);
      @(posedge clk); #1; mem_read = 1'b0;
      @(negedge clk);
      chk("flt_err_clr", err, 0);
      @(posedge clk); #1;
    end
    last_rd = '0;
    mem_write = 1'b1; addr = BASE + 4 * (2 ** AW); st_val = 32'h1;
    @(posedge clk); #1; @(negedge clk);
    chk("flt_hi_err", err, 1);
    chk("flt_hi_we_n", sram_we_n, 1);
    @(posedge clk); #1; mem_write = 1'b0;
`else
    // Below-base address wraps modulo SRAM size.
    do_access(1'b0, 32'd1000, '0, 1'b0);
    chk("wrap_addr", sram_addr, 32'h0000FFFA);
`endif

    // Randomized mix of loads and stores with optional idle gaps.
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      i  = $urandom_range(0, 255);
      d  = $urandom;
      a  = BASE + 4 * i;
`ifndef MEM_RANGE_CHECK_EN
      a  = a | 32'($urandom_range(0, 3));
`endif
      do_access(wr, a, d, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("gap_ready", ready, 1);
        chk("gap_rd", rd_data, last_rd);
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
